ahb_lite_master: RTL and testbench

Single-outstanding AHB-Lite initiator that turns a simple valid/ready command interface into SINGLE NONSEQ bus transfers. Slaves such as ahb_uart and ahb_sram are driven from it. Used by the debug/boot loader path and block-level benches as the bus-driving end of our AHB slaves. Handles slave wait states, two-cycle ERROR responses and local misalignment rejection.

---
 rtl/ahb_lite_master.sv | 163 ++++++++++++++++
 tb/tb_ahb_lite_master.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_lite_master.sv
`default_nettype none
// ============================================================================
// Module   : ahb_lite_master
// Purpose  : Single-outstanding AHB-Lite initiator. Converts a valid/ready
//            command into one SINGLE NONSEQ transfer, waits out slave wait
//            states, folds two-cycle ERROR responses into rsp_err_o and
//            rejects misaligned/oversized commands locally with no bus access.
// Ports    : hclk, hresetn          - clock, async active-low reset
//            cmd_*                  - command request (valid/ready handshake)
//            rsp_*                  - one-cycle response pulse + held data/err
//            haddr_o .. hwdata_o    - AHB-Lite master outputs (registered)
//            hready_i, hresp_i,
//            hrdata_i               - AHB-Lite slave response inputs
// Revision : 1.0 - initial release
// ============================================================================
module ahb_lite_master #(
   parameter int AW = 32,
   parameter int DW = 32
) (
   input  logic          hclk,
   input  logic          hresetn,
   input  logic          cmd_valid_i,
   output logic          cmd_ready_o,
   input  logic          cmd_write_i,
   input  logic [AW-1:0] cmd_addr_i,
   input  logic [2:0]    cmd_size_i,
   input  logic [DW-1:0] cmd_wdata_i,
   output logic          rsp_valid_o,
   output logic [DW-1:0] rsp_rdata_o,
   output logic          rsp_err_o,
   output logic [AW-1:0] haddr_o,
   output logic          hwrite_o,
   output logic [2:0]    hsize_o,
   output logic [2:0]    hburst_o,
   output logic [1:0]    htrans_o,
   output logic [DW-1:0] hwdata_o,
   input  logic          hready_i,
   input  logic          hresp_i,
   input  logic [DW-1:0] hrdata_i
);

   localparam logic [1:0] C_HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] C_HTRANS_NONSEQ = 2'b10;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ADDR = 2'd1,
      S_DATA = 2'd2,
      S_REJ  = 2'd3
   } state_t;

   state_t        r_state;
   state_t        w_next;
   logic          w_accept;
   logic          w_illegal;
   logic          r_err;     // ERROR seen in the first (hready=0) cycle
   logic [DW-1:0] r_wdata;   // write data held until the data phase starts

   assign cmd_ready_o = (r_state == S_IDLE);
   assign hburst_o    = 3'b000;
   assign w_accept    = cmd_valid_i && (r_state == S_IDLE);

   // Sizes above a word, and halfword/word accesses not naturally aligned.
   assign w_illegal = (cmd_size_i > 3'd2)
                   || ((cmd_size_i == 3'd1) && cmd_addr_i[0])
                   || ((cmd_size_i == 3'd2) && (cmd_addr_i[1:0] != 2'b00));

   always_ff @(posedge hclk or negedge hresetn) begin
      if (!hresetn) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               w_next = w_illegal ? S_REJ : S_ADDR;
            end
         end
         S_ADDR: begin
            if (hready_i) begin
               w_next = S_DATA;
            end
         end
         S_DATA: begin
            if (hready_i) begin
               w_next = S_IDLE;
            end
         end
         S_REJ:   w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge hclk or negedge hresetn) begin
      if (!hresetn) begin
         haddr_o     <= '0;
         hwrite_o    <= 1'b0;
         hsize_o     <= 3'd0;
         htrans_o    <= C_HTRANS_IDLE;
         hwdata_o    <= '0;
         r_wdata     <= '0;
         r_err       <= 1'b0;
         rsp_valid_o <= 1'b0;
         rsp_err_o   <= 1'b0;
         rsp_rdata_o <= '0;
      end else begin
         rsp_valid_o <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_err <= 1'b0;
                  if (!w_illegal) begin
                     haddr_o  <= cmd_addr_i;
                     hwrite_o <= cmd_write_i;
                     hsize_o  <= cmd_size_i;
                     htrans_o <= C_HTRANS_NONSEQ;
                     r_wdata  <= cmd_wdata_i;
                  end
               end
            end
            S_ADDR: begin
               // Address phase ends; reads leave hwdata untouched.
               if (hready_i) begin
                  htrans_o <= C_HTRANS_IDLE;
                  if (hwrite_o) begin
                     hwdata_o <= r_wdata;
                  end
               end
            end
            S_DATA: begin
               if (!hready_i) begin
                  if (hresp_i) begin
                     r_err <= 1'b1;
                  end
               end else begin
                  rsp_valid_o <= 1'b1;
                  rsp_err_o   <= r_err | hresp_i;
                  if (!hwrite_o && !r_err && !hresp_i) begin
                     rsp_rdata_o <= hrdata_i;
                  end else begin
                     rsp_rdata_o <= '0;
                  end
               end
            end
            S_REJ: begin
               rsp_valid_o <= 1'b1;
               rsp_err_o   <= 1'b1;
               rsp_rdata_o <= '0;
            end
            default: begin
               htrans_o <= C_HTRANS_IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_ahb_lite_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_ahb_lite_master
// Purpose  : Self-checking bench for ahb_lite_master. Table of directed
//            commands with a scripted slave (wait states, ERROR responses),
//            plus hand-written back-to-back and mid-transfer reset sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ahb_lite_master;

   logic        hclk;
   logic        hresetn;
   logic        cmd_valid;
   logic        cmd_ready;
   logic        cmd_write;
   logic [31:0] cmd_addr;
   logic [2:0]  cmd_size;
   logic [31:0] cmd_wdata;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic [31:0] haddr;
   logic        hwrite;
   logic [2:0]  hsize;
   logic [2:0]  hburst;
   logic [1:0]  htrans;
   logic [31:0] hwdata;
   logic        hready;
   logic        hresp;
   logic [31:0] hrdata;

   int total = 0;
   int bad   = 0;
   logic [31:0] last_wdata;   // expected hwdata value carried across reads

   ahb_lite_master #(.AW(32), .DW(32)) u_dut (
      .hclk        (hclk),
      .hresetn     (hresetn),
      .cmd_valid_i (cmd_valid),
      .cmd_ready_o (cmd_ready),
      .cmd_write_i (cmd_write),
      .cmd_addr_i  (cmd_addr),
      .cmd_size_i  (cmd_size),
      .cmd_wdata_i (cmd_wdata),
      .rsp_valid_o (rsp_valid),
      .rsp_rdata_o (rsp_rdata),
      .rsp_err_o   (rsp_err),
      .haddr_o     (haddr),
      .hwrite_o    (hwrite),
      .hsize_o     (hsize),
      .hburst_o    (hburst),
      .htrans_o    (htrans),
      .hwdata_o    (hwdata),
      .hready_i    (hready),
      .hresp_i     (hresp),
      .hrdata_i    (hrdata)
   );

   initial hclk = 1'b0;
   always #5 hclk = ~hclk;

   typedef struct {
      logic        wr;
      logic [31:0] addr;
      logic [2:0]  size;
      logic [31:0] wdata;
      int          waits;      // data-phase wait cycles
      logic        slv_err;    // slave answers with two-cycle ERROR
      logic [31:0] rdata;      // hrdata on the completing cycle
      logic        rej;        // expected local reject
      logic        exp_err;
      logic [31:0] exp_rdata;
   } vec_t;

   vec_t vecs [9];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge hclk);
      @(negedge hclk);
   endtask

   // Starts at a negedge with hready=1; ends at a negedge, bus idle.
   task automatic run_txn(input vec_t v);
      cmd_valid = 1'b1;
      cmd_write = v.wr;
      cmd_addr  = v.addr;
      cmd_size  = v.size;
      cmd_wdata = v.wdata;
      chk("ready_before", {31'd0, cmd_ready}, 32'd1);
      step();
      cmd_valid = 1'b0;
      cmd_addr  = 32'hFFFF_FFFF;
      cmd_wdata = 32'hFFFF_FFFF;
      if (v.rej) begin
         chk("rej_htrans", {30'd0, htrans}, 32'd0);
         chk("rej_ready", {31'd0, cmd_ready}, 32'd0);
         step();
         chk("rej_rsp_valid", {31'd0, rsp_valid}, 32'd1);
         chk("rej_rsp_err", {31'd0, rsp_err}, 32'd1);
         chk("rej_rsp_rdata", rsp_rdata, 32'd0);
         chk("rej_htrans2", {30'd0, htrans}, 32'd0);
         step();
         chk("rej_rsp_drop", {31'd0, rsp_valid}, 32'd0);
         chk("rej_err_hold", {31'd0, rsp_err}, 32'd1);
         return;
      end
      // cycle 1: address phase
      chk("nonseq", {30'd0, htrans}, 32'd2);
      chk("haddr", haddr, v.addr);
      chk("hwrite", {31'd0, hwrite}, {31'd0, v.wr});
      chk("hsize", {29'd0, hsize}, {29'd0, v.size});
      chk("hburst", {29'd0, hburst}, 32'd0);
      chk("ready_busy", {31'd0, cmd_ready}, 32'd0);
      step();
      // cycle 2: data phase
      if (v.wr) last_wdata = v.wdata;
      chk("dp_htrans", {30'd0, htrans}, 32'd0);
      chk("dp_haddr", haddr, v.addr);
      chk("dp_hwdata", hwdata, last_wdata);
      for (int w = 0; w < v.waits; w++) begin
         hready = 1'b0;
         hresp  = v.slv_err && (w == v.waits - 1);
         hrdata = 32'hFFFF_FFFF;
         step();
         chk("wait_rsp_valid", {31'd0, rsp_valid}, 32'd0);
         chk("wait_ready", {31'd0, cmd_ready}, 32'd0);
         chk("wait_htrans", {30'd0, htrans}, 32'd0);
      end
      hready = 1'b1;
      hresp  = v.slv_err;
      hrdata = v.rdata;
      step();
      hresp  = 1'b0;
      hrdata = 32'd0;
      chk("rsp_valid", {31'd0, rsp_valid}, 32'd1);
      chk("rsp_err", {31'd0, rsp_err}, {31'd0, v.exp_err});
      chk("rsp_rdata", rsp_rdata, v.exp_rdata);
      chk("rsp_ready", {31'd0, cmd_ready}, 32'd1);
      step();
      chk("rsp_drop", {31'd0, rsp_valid}, 32'd0);
      chk("rsp_err_hold", {31'd0, rsp_err}, {31'd0, v.exp_err});
      chk("rsp_rdata_hold", rsp_rdata, v.exp_rdata);
      chk("post_htrans", {30'd0, htrans}, 32'd0);
   endtask

   initial begin
      //           wr    addr          size  wdata         wt err rdata         rej  e_err e_rdata
      vecs[0] = '{1'b1, 32'h0000_0004, 3'd2, 32'h0000_0003, 0, 1'b0, 32'h0000_00EE, 1'b0, 1'b0, 32'h0};
      vecs[1] = '{1'b0, 32'h0000_0000, 3'd2, 32'h0,         2, 1'b0, 32'h0000_00A3, 1'b0, 1'b0, 32'h0000_00A3};
      vecs[2] = '{1'b1, 32'h0000_0008, 3'd2, 32'h1234_5678, 1, 1'b1, 32'h0000_0055, 1'b0, 1'b1, 32'h0};
      vecs[3] = '{1'b1, 32'h0000_0006, 3'd2, 32'h0,         0, 1'b0, 32'h0,         1'b1, 1'b1, 32'h0};
      vecs[4] = '{1'b0, 32'h0000_0000, 3'd3, 32'h0,         0, 1'b0, 32'h0,         1'b1, 1'b1, 32'h0};
      vecs[5] = '{1'b0, 32'h0000_0002, 3'd1, 32'h0,         0, 1'b0, 32'h1234_5678, 1'b0, 1'b0, 32'h1234_5678};
      vecs[6] = '{1'b0, 32'h0000_0003, 3'd1, 32'h0,         0, 1'b0, 32'h0,         1'b1, 1'b1, 32'h0};
      vecs[7] = '{1'b0, 32'h0000_0003, 3'd0, 32'h0,         1, 1'b0, 32'hCAFE_F00D, 1'b0, 1'b0, 32'hCAFE_F00D};
      vecs[8] = '{1'b0, 32'h0000_0010, 3'd2, 32'h0,         1, 1'b1, 32'h0000_0077, 1'b0, 1'b1, 32'h0};

      hresetn    = 1'b0;
      cmd_valid  = 1'b0;
      cmd_write  = 1'b0;
      cmd_addr   = 32'd0;
      cmd_size   = 3'd0;
      cmd_wdata  = 32'd0;
      hready     = 1'b1;
      hresp      = 1'b0;
      hrdata     = 32'd0;
      last_wdata = 32'd0;

      repeat (2) @(negedge hclk);
      chk("rst_htrans", {30'd0, htrans}, 32'd0);
      chk("rst_haddr", haddr, 32'd0);
      chk("rst_hwdata", hwdata, 32'd0);
      chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      chk("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
      chk("rst_rsp_rdata", rsp_rdata, 32'd0);
      chk("rst_ready", {31'd0, cmd_ready}, 32'd1);
      hresetn = 1'b1;
      step();

      for (int i = 0; i < 9; i++) begin
         run_txn(vecs[i]);
      end

      // Back-to-back writes with cmd_valid held high.
      cmd_valid = 1'b1;
      cmd_write = 1'b1;
      cmd_addr  = 32'h0;
      cmd_size  = 3'd2;
      cmd_wdata = 32'h0000_0011;
      step();
      chk("b2b_nonseq1", {30'd0, htrans}, 32'd2);
      chk("b2b_haddr1", haddr, 32'h0);
      cmd_addr  = 32'h4;
      cmd_wdata = 32'h0000_0022;
      step();
      chk("b2b_dp1_htrans", {30'd0, htrans}, 32'd0);
      chk("b2b_dp1_hwdata", hwdata, 32'h0000_0011);
      chk("b2b_dp1_ready", {31'd0, cmd_ready}, 32'd0);
      step();
      chk("b2b_rsp1", {31'd0, rsp_valid}, 32'd1);
      chk("b2b_rsp1_htrans", {30'd0, htrans}, 32'd0);
      chk("b2b_rsp1_ready", {31'd0, cmd_ready}, 32'd1);
      step();
      cmd_valid = 1'b0;
      chk("b2b_nonseq2", {30'd0, htrans}, 32'd2);
      chk("b2b_haddr2", haddr, 32'h4);
      chk("b2b_rsp1_drop", {31'd0, rsp_valid}, 32'd0);
      step();
      chk("b2b_dp2_hwdata", hwdata, 32'h0000_0022);
      step();
      chk("b2b_rsp2", {31'd0, rsp_valid}, 32'd1);
      chk("b2b_rsp2_err", {31'd0, rsp_err}, 32'd0);
      step();
      last_wdata = 32'h0000_0022;

      // Reset asserted during a data-phase wait state.
      cmd_valid = 1'b1;
      cmd_write = 1'b1;
      cmd_addr  = 32'h20;
      cmd_size  = 3'd2;
      cmd_wdata = 32'h0000_0033;
      step();
      cmd_valid = 1'b0;
      step();
      hready = 1'b0;
      step();
      #2 hresetn = 1'b0;
      #1;
      chk("arst_htrans", {30'd0, htrans}, 32'd0);
      chk("arst_haddr", haddr, 32'd0);
      chk("arst_hwrite", {31'd0, hwrite}, 32'd0);
      chk("arst_hsize", {29'd0, hsize}, 32'd0);
      chk("arst_hwdata", hwdata, 32'd0);
      chk("arst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      @(posedge hclk);
      @(negedge hclk);
      hresetn = 1'b1;
      hready  = 1'b1;
      last_wdata = 32'd0;
      for (int k = 0; k < 3; k++) begin
         step();
         chk("arst_no_rsp", {31'd0, rsp_valid}, 32'd0);
         chk("arst_idle", {30'd0, htrans}, 32'd0);
      end
      run_txn(vecs[1]);
      run_txn(vecs[0]);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
